knn_topk_vote: RTL and testbench

Streaming K-nearest-neighbour selector and majority voter for the KNN colour classifier. It sits directly downstream of the per-entry RGB565 squared-distance stage and consumes one (distance, label) pair per cycle while the dictionary is scanned. It keeps the K smallest distances in a sorted list and, after the last dictionary entry, votes over their labels. It emits one class label per image pixel, together with the nearest distance.

---
 rtl/knn_topk_vote_pkg.sv | 16 +
 rtl/knn_topk_insert.sv | 58 +++++
 rtl/knn_topk_vote.sv | 138 +++++++++++++
 tb/tb_knn_topk_vote.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_topk_vote_pkg.sv
// Shared widths, defaults and FSM state type for the KNN top-K selector/voter.
package knn_topk_vote_pkg;

    localparam int KNN_DIST_W    = 14;
    localparam int KNN_LABEL_W   = 4;
    localparam int KNN_NUM_CLASS = 10;
    localparam int KNN_K         = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VOTE    = 2'd2,
        ST_DONE    = 2'd3
    } knn_state_t;

endpackage

// File: rtl/knn_topk_insert.sv
// K-slot list kept sorted by ascending distance; empty slots always sit at the tail.
module knn_topk_insert
    import knn_topk_vote_pkg::*;
#(
    parameter int K       = KNN_K,
    parameter int DIST_W  = KNN_DIST_W,
    parameter int LABEL_W = KNN_LABEL_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          insert,
    input  logic [DIST_W-1:0]             in_dist,
    input  logic [LABEL_W-1:0]            in_label,
    output logic [K-1:0]                  slot_valid,
    output logic [K-1:0][DIST_W-1:0]      slot_dist,
    output logic [K-1:0][LABEL_W-1:0]     slot_label
);

    // Sorted order with empties last makes take[] monotonic: once set, it stays set.
    logic [K-1:0] take;

    always_comb begin
        take = '0;
        for (int unsigned i = 0; i < K; i++) begin
            take[i] = !slot_valid[i] || (in_dist < slot_dist[i]);
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                slot_valid[i] <= 1'b0;
                slot_dist[i]  <= '1;
                slot_label[i] <= '0;
            end else if (clear) begin
                slot_valid[i] <= 1'b0;
                slot_dist[i]  <= '1;
                slot_label[i] <= '0;
            end else if (insert && take[i]) begin
                if (i == 0) begin
                    slot_valid[i] <= 1'b1;
                    slot_dist[i]  <= in_dist;
                    slot_label[i] <= in_label;
                end else if (!take[(i > 0) ? i-1 : 0]) begin
                    slot_valid[i] <= 1'b1;
                    slot_dist[i]  <= in_dist;
                    slot_label[i] <= in_label;
                end else begin
                    slot_valid[i] <= slot_valid[(i > 0) ? i-1 : 0];
                    slot_dist[i]  <= slot_dist[(i > 0) ? i-1 : 0];
                    slot_label[i] <= slot_label[(i > 0) ? i-1 : 0];
                end
            end
        end
    end

endmodule

// File: rtl/knn_topk_vote.sv
// Streaming K-nearest selector: collects (distance,label) beats, then scans classes to vote.
module knn_topk_vote
    import knn_topk_vote_pkg::*;
#(
    parameter int K         = KNN_K,
    parameter int DIST_W    = KNN_DIST_W,
    parameter int LABEL_W   = KNN_LABEL_W,
    parameter int NUM_CLASS = KNN_NUM_CLASS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dist_valid,
    output logic               dist_ready,
    input  logic [DIST_W-1:0]  distance,
    input  logic [LABEL_W-1:0] label,
    input  logic               dist_last,
    output logic               busy,
    output logic               result_valid,
    output logic [LABEL_W-1:0] result_label,
    output logic [DIST_W-1:0]  result_distance
);

    localparam int CNT_W = $clog2(K + 1);

    knn_state_t state;

    logic [K-1:0]               slot_valid;
    logic [K-1:0][DIST_W-1:0]   slot_dist;
    logic [K-1:0][LABEL_W-1:0]  slot_label;

    logic                       accept;
    logic                       label_ok;
    logic [LABEL_W-1:0]         vote_cls;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           first;
    logic                       better;
    logic [LABEL_W-1:0]         best_label;
    logic [CNT_W-1:0]           best_count;
    logic [CNT_W-1:0]           best_first;
    logic                       unused_dist;

    assign accept      = dist_valid && dist_ready;
    assign label_ok    = int'(label) < NUM_CLASS;
    assign unused_dist = ^slot_dist;

    knn_topk_insert #(
        .K       (K),
        .DIST_W  (DIST_W),
        .LABEL_W (LABEL_W)
    ) u_insert (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == ST_IDLE),
        .insert     (accept && label_ok),
        .in_dist    (distance),
        .in_label   (label),
        .slot_valid (slot_valid),
        .slot_dist  (slot_dist),
        .slot_label (slot_label)
    );

    // Score of the class currently under scan; first == K means the class is absent.
    always_comb begin
        cnt   = '0;
        first = CNT_W'(K);
        for (int unsigned i = 0; i < K; i++) begin
            if (slot_valid[i] && (slot_label[i] == vote_cls)) begin
                if (cnt == '0) begin
                    first = CNT_W'(i);
                end
                cnt = cnt + CNT_W'(1);
            end
        end
        better = (cnt > best_count) ||
                 ((cnt == best_count) && (cnt != '0) && (first < best_first));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            dist_ready      <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            result_label    <= '0;
            result_distance <= '0;
            vote_cls        <= '0;
            best_label      <= '0;
            best_count      <= '0;
            best_first      <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_COLLECT;
                        dist_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (accept && dist_last) begin
                        state      <= ST_VOTE;
                        dist_ready <= 1'b0;
                        vote_cls   <= '0;
                        best_label <= '0;
                        best_count <= '0;
                        best_first <= CNT_W'(K);
                    end
                end
                ST_VOTE: begin
                    if (better) begin
                        best_label <= vote_cls;
                        best_count <= cnt;
                        best_first <= first;
                    end
                    vote_cls <= vote_cls + LABEL_W'(1);
                    if (vote_cls == LABEL_W'(NUM_CLASS - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    result_valid    <= 1'b1;
                    result_label    <= best_label;
                    result_distance <= slot_dist[0];
                    busy            <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    dist_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_topk_vote.sv
// Directed-vector bench for knn_topk_vote with hand-computed expectations.
module tb_knn_topk_vote;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        dist_valid;
    logic        dist_ready;
    logic [13:0] distance;
    logic [3:0]  label;
    logic        dist_last;
    logic        busy;
    logic        result_valid;
    logic [3:0]  result_label;
    logic [13:0] result_distance;

    int errors = 0;
    int checks = 0;

    knn_topk_vote #(
        .K         (3),
        .DIST_W    (14),
        .LABEL_W   (4),
        .NUM_CLASS (10)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dist_valid      (dist_valid),
        .dist_ready      (dist_ready),
        .distance        (distance),
        .label           (label),
        .dist_last       (dist_last),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_label    (result_label),
        .result_distance (result_distance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [13:0] d, input logic [3:0] l, input logic last);
        @(negedge clk);
        dist_valid = 1'b1;
        distance   = d;
        label      = l;
        dist_last  = last;
        @(posedge clk);
        #1;
        dist_valid = 1'b0;
        dist_last  = 1'b0;
    endtask

    // Counts edges after the last accepted beat until result_valid is seen.
    task automatic wait_result(output int lat, output logic timed_out);
        lat       = 0;
        timed_out = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (result_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (dist_ready !== 1'b0) begin errors++; $display("FAIL reset_dist_ready got=%b exp=0", dist_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got=%b exp=0", result_valid); end
        checks++;
        if (result_label !== 4'd0) begin errors++; $display("FAIL reset_result_label got=%0d exp=0", result_label); end
        checks++;
        if (result_distance !== 14'd0) begin errors++; $display("FAIL reset_result_distance got=%0d exp=0", result_distance); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_majority();
        int   lat;
        logic to;
        pulse_start();
        checks++;
        if (dist_ready !== 1'b1) begin errors++; $display("FAIL maj_ready_after_start got=%b exp=1", dist_ready); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL maj_busy_after_start got=%b exp=1", busy); end
        send_beat(14'd100, 4'd2, 1'b0);
        send_beat(14'd50,  4'd5, 1'b0);
        send_beat(14'd75,  4'd5, 1'b0);
        send_beat(14'd200, 4'd1, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL maj_timeout got=none exp=result_valid"); end
        checks++;
        if (lat != 11) begin errors++; $display("FAIL maj_latency got=%0d exp=11", lat); end
        checks++;
        if (result_label !== 4'd5) begin errors++; $display("FAIL maj_label got=%0d exp=5", result_label); end
        checks++;
        if (result_distance !== 14'd50) begin errors++; $display("FAIL maj_distance got=%0d exp=50", result_distance); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL maj_busy_with_valid got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL maj_valid_pulse got=%b exp=0", result_valid); end
        checks++;
        if (result_label !== 4'd5) begin errors++; $display("FAIL maj_label_held got=%0d exp=5", result_label); end
    endtask

    task automatic test_tie_break();
        int   lat;
        logic to;
        pulse_start();
        send_beat(14'd30, 4'd1, 1'b0);
        send_beat(14'd30, 4'd2, 1'b0);
        send_beat(14'd30, 4'd3, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL tie_timeout got=none exp=result_valid"); end
        checks++;
        if (result_label !== 4'd1) begin errors++; $display("FAIL tie_label got=%0d exp=1", result_label); end
        checks++;
        if (result_distance !== 14'd30) begin errors++; $display("FAIL tie_distance got=%0d exp=30", result_distance); end
    endtask

    task automatic test_fewer_than_k();
        int   lat;
        logic to;
        pulse_start();
        send_beat(14'd0, 4'd7, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL fewer_timeout got=none exp=result_valid"); end
        checks++;
        if (result_label !== 4'd7) begin errors++; $display("FAIL fewer_label got=%0d exp=7", result_label); end
        checks++;
        if (result_distance !== 14'd0) begin errors++; $display("FAIL fewer_distance got=%0d exp=0", result_distance); end
    endtask

    task automatic test_invalid_label();
        int   lat;
        logic to;
        pulse_start();
        send_beat(14'd0,   4'd12, 1'b0);
        send_beat(14'd500, 4'd4,  1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL inv_timeout got=none exp=result_valid"); end
        checks++;
        if (result_label !== 4'd4) begin errors++; $display("FAIL inv_label got=%0d exp=4", result_label); end
        checks++;
        if (result_distance !== 14'd500) begin errors++; $display("FAIL inv_distance got=%0d exp=500", result_distance); end

        pulse_start();
        send_beat(14'd0, 4'd15, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL allinv_timeout got=none exp=result_valid"); end
        checks++;
        if (lat != 11) begin errors++; $display("FAIL allinv_latency got=%0d exp=11", lat); end
        checks++;
        if (result_label !== 4'd0) begin errors++; $display("FAIL allinv_label got=%0d exp=0", result_label); end
        checks++;
        if (result_distance !== 14'd16383) begin errors++; $display("FAIL allinv_distance got=%0d exp=16383", result_distance); end
    endtask

    task automatic test_reset_mid_collect();
        int   lat;
        logic to;
        pulse_start();
        send_beat(14'd10, 4'd3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dist_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", dist_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++;
        if (result_label !== 4'd0 || result_distance !== 14'd0) begin
            errors++;
            $display("FAIL midrst_result got=%0d/%0d exp=0/0", result_label, result_distance);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_beat(14'd900, 4'd6, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL midrst_timeout got=none exp=result_valid"); end
        checks++;
        if (result_label !== 4'd6) begin errors++; $display("FAIL midrst_label got=%0d exp=6", result_label); end
        checks++;
        if (result_distance !== 14'd900) begin errors++; $display("FAIL midrst_distance got=%0d exp=900", result_distance); end
    endtask

    task automatic test_protocol();
        int   lat;
        logic to;
        pulse_start();
        send_beat(14'd40, 4'd8, 1'b1);
        // Hold a tempting beat and a start pulse while the vote scan runs.
        @(negedge clk);
        dist_valid = 1'b1;
        distance   = 14'd1;
        label      = 4'd9;
        dist_last  = 1'b1;
        start      = 1'b1;
        checks++;
        if (dist_ready !== 1'b0) begin errors++; $display("FAIL proto_ready_in_vote got=%b exp=0", dist_ready); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL proto_busy_in_vote got=%b exp=1", busy); end
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL proto_timeout got=none exp=result_valid"); end
        checks++;
        if (lat != 10) begin errors++; $display("FAIL proto_latency got=%0d exp=10", lat); end
        checks++;
        if (result_label !== 4'd8) begin errors++; $display("FAIL proto_label got=%0d exp=8", result_label); end
        checks++;
        if (result_distance !== 14'd40) begin errors++; $display("FAIL proto_distance got=%0d exp=40", result_distance); end
        @(posedge clk);
        #1;
        checks++;
        if (dist_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL proto_idle_after got=%b/%b exp=0/0", dist_ready, busy);
        end
        dist_valid = 1'b0;
        dist_last  = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic to;
        pulse_start();
        send_beat(14'd9, 4'd0, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to || result_label !== 4'd0 || result_distance !== 14'd9) begin
            errors++;
            $display("FAIL b2b_first got=%0d/%0d exp=0/9", result_label, result_distance);
        end
        pulse_start();
        checks++;
        if (dist_ready !== 1'b1) begin errors++; $display("FAIL b2b_restart_ready got=%b exp=1", dist_ready); end
        send_beat(14'd5, 4'd3, 1'b0);
        send_beat(14'd5, 4'd3, 1'b0);
        send_beat(14'd1, 4'd9, 1'b1);
        wait_result(lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout got=none exp=result_valid"); end
        checks++;
        if (result_label !== 4'd3) begin errors++; $display("FAIL b2b_label got=%0d exp=3", result_label); end
        checks++;
        if (result_distance !== 14'd1) begin errors++; $display("FAIL b2b_distance got=%0d exp=1", result_distance); end
    endtask

    initial begin
        start      = 1'b0;
        dist_valid = 1'b0;
        distance   = '0;
        label      = '0;
        dist_last  = 1'b0;
        rst_n      = 1'b0;
        test_reset();
        test_majority();
        test_tie_break();
        test_fewer_than_k();
        test_invalid_label();
        test_reset_mid_collect();
        test_protocol();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
